// File: rtl/regbank_dump_ctrl_pkg.sv
// Shared debug-unit definitions for the register bank dump sequencer.
// State encoding, default geometry and a counter width helper.
package regbank_dump_ctrl_pkg;

    localparam int DEF_DATA_SIZE  = 32;
    localparam int DEF_ADDR_SIZE  = 5;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_BYTE_SIZE  = 8;
    localparam int BYTES_PER_WORD = DEF_DATA_SIZE / DEF_BYTE_SIZE;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_READ    = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_SEND    = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regbank_dump_ctrl_serializer.sv
// Splits a loaded word into bytes, LSB first, advancing one byte
// per valid/ready handshake and flagging the final byte of the word.
module word_serializer
    import regbank_dump_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int BYTE_SIZE = DEF_BYTE_SIZE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic [DATA_SIZE-1:0] i_word,
    input  logic                 i_valid,
    input  logic                 i_ready,
    output logic [BYTE_SIZE-1:0] o_data,
    output logic                 o_last
);

    localparam int BPW = DATA_SIZE / BYTE_SIZE;
    localparam int CW  = cnt_width(BPW);

    logic [DATA_SIZE-1:0] shift;
    logic [CW-1:0]        byte_cnt;
    logic                 fire;

    assign fire = i_valid & i_ready;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (i_load) begin
            shift    <= i_word;
            byte_cnt <= '0;
        end else if (fire) begin
            shift    <= shift >> BYTE_SIZE;
            byte_cnt <= byte_cnt + CW'(1);
        end
    end

    assign o_data = shift[BYTE_SIZE-1:0];
    assign o_last = (byte_cnt == CW'(BPW - 1));

endmodule

// File: rtl/regbank_dump_ctrl.sv
// Debug sequencer: stalls the pipeline, reads every register through the
// bank debug port and streams each word out over the TX byte handshake.
module regbank_dump_ctrl
    import regbank_dump_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int BYTE_SIZE = DEF_BYTE_SIZE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic                 o_stall,
    output logic                 o_read_enable,
    output logic [ADDR_SIZE-1:0] o_read_addr,
    input  logic [DATA_SIZE-1:0] i_reg_data,
    output logic [BYTE_SIZE-1:0] o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(NUM_REGS - 1);

    state_t               state;
    state_t               next_state;
    logic [ADDR_SIZE-1:0] addr;
    logic                 done_q;
    logic                 send;
    logic                 tx_fire;
    logic                 ser_last;
    logic                 word_end;

    assign send     = (state == ST_SEND);
    assign tx_fire  = send & i_tx_ready;
    assign word_end = tx_fire & ser_last;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= next_state;
    end

    // done is delayed a cycle so it lands on the first IDLE cycle
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            if (state == ST_DONE || (state == ST_IDLE && i_start))
                addr <= '0;
            else if (word_end && addr != LAST_ADDR)
                addr <= addr + ADDR_SIZE'(1);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (i_start) next_state = ST_READ;
            ST_READ:    next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_SEND;
            ST_SEND: begin
                if (word_end)
                    next_state = (addr == LAST_ADDR) ? ST_DONE : ST_READ;
            end
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_stall       = (state != ST_IDLE);
        o_busy        = (state != ST_IDLE);
        o_read_enable = (state == ST_READ);
        o_read_addr   = addr;
        o_tx_valid    = send;
        o_done        = done_q;
    end

    word_serializer #(
        .DATA_SIZE(DATA_SIZE),
        .BYTE_SIZE(BYTE_SIZE)
    ) u_ser (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (state == ST_CAPTURE),
        .i_word  (i_reg_data),
        .i_valid (send),
        .i_ready (i_tx_ready),
        .o_data  (o_tx_data),
        .o_last  (ser_last)
    );

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Directed bench for the register bank dump sequencer.
// Default geometry instance plus a 2-register, 16-bit instance.
module tb_regbank_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, ready;
    logic        stall, rd_en, busy, done, tx_valid;
    logic [4:0]  rd_addr;
    logic [31:0] reg_data = '0;
    logic [7:0]  tx_data;

    logic        start2, ready2;
    logic        stall2, rd_en2, busy2, done2, tx_valid2;
    logic [4:0]  rd_addr2;
    logic [15:0] reg_data2 = '0;
    logic [7:0]  tx_data2;

    regbank_dump_ctrl dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .o_stall       (stall),
        .o_read_enable (rd_en),
        .o_read_addr   (rd_addr),
        .i_reg_data    (reg_data),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (ready),
        .o_busy        (busy),
        .o_done        (done)
    );

    regbank_dump_ctrl #(
        .DATA_SIZE(16),
        .NUM_REGS (2)
    ) dut2 (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_start       (start2),
        .o_stall       (stall2),
        .o_read_enable (rd_en2),
        .o_read_addr   (rd_addr2),
        .i_reg_data    (reg_data2),
        .o_tx_data     (tx_data2),
        .o_tx_valid    (tx_valid2),
        .i_tx_ready    (ready2),
        .o_busy        (busy2),
        .o_done        (done2)
    );

    // registered bank models: data valid one cycle after the strobe
    always @(posedge clk) begin
        if (rd_en) reg_data <= 32'h1000_0000 + 32'(rd_addr);
        if (rd_en2) reg_data2 <= 16'hC3A0 + 16'(rd_addr2);
    end

    int errors = 0;
    int checks = 0;
    int rel;
    logic [7:0] rx_bytes[$];
    int raddrs[$];
    int stall_cnt, first_stall, last_stall;
    int done_cnt, done_at, first_valid;
    int stall_viol, stable_viol;
    logic prev_hold;
    logic [7:0] prev_data;

    task automatic clear_stats();
        rx_bytes.delete();
        raddrs.delete();
        stall_cnt = 0; first_stall = -1; last_stall = -1;
        done_cnt = 0; done_at = -1; first_valid = -1;
        stall_viol = 0; stable_viol = 0;
        prev_hold = 1'b0; prev_data = '0;
    endtask

    task automatic sample();
        if (stall) begin
            stall_cnt++;
            if (first_stall < 0) first_stall = rel;
            last_stall = rel;
        end
        if (rd_en) begin
            raddrs.push_back(int'(rd_addr));
            if (!stall) stall_viol++;
        end
        if (tx_valid && first_valid < 0) first_valid = rel;
        if (prev_hold && (!tx_valid || tx_data !== prev_data)) stable_viol++;
        prev_hold = tx_valid && !ready;
        prev_data = tx_data;
        if (tx_valid && ready) rx_bytes.push_back(tx_data);
        if (done) begin
            done_cnt++;
            done_at = rel;
        end
    endtask

    function automatic int stream_err();
        int n = 0;
        logic [31:0] w;
        logic [7:0] e;
        if (rx_bytes.size() != 128) n++;
        for (int i = 0; i < rx_bytes.size() && i < 128; i++) begin
            w = 32'h1000_0000 + 32'(i / 4);
            e = 8'(w >> (8 * (i % 4)));
            if (rx_bytes[i] !== e) n++;
        end
        return n;
    endfunction

    function automatic int addr_err();
        int n = 0;
        if (raddrs.size() != 32) n++;
        for (int i = 0; i < raddrs.size() && i < 32; i++)
            if (raddrs[i] != i) n++;
        return n;
    endfunction

    // mode 0: ready tied high, mode 1: ready pattern 1-0-0
    task automatic run_dump(input int mode, input bit inject);
        bit injected = 1'b0;
        int tail = 0;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        ready = (mode == 0);
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk); #1;
            rel = c;
            start = 1'b0;
            if (inject && !injected && raddrs.size() == 11) begin
                start = 1'b1;
                injected = 1'b1;
            end
            ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            @(negedge clk);
            sample();
            if (done_cnt > 0) tail++;
            if (tail > 5) break;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL run_timeout: done_cnt=%0d required >0", done_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, busy, rd_en, tx_valid, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {stall, busy, rd_en, tx_valid, done});
        end
        checks++;
        if ({rd_addr, tx_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d data=%h required 0", rd_addr, tx_data);
        end
        checks++;
        if ({stall2, busy2, rd_en2, tx_valid2, done2, tx_data2} !== 13'h0) begin
            errors++;
            $display("FAIL reset_dut2: outputs not all zero");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_dump();
        int n;
        run_dump(0, 1'b0);
        n = stream_err();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL full_stream: %0d bad of %0d bytes required 0 bad of 128",
                     n, rx_bytes.size());
        end
        checks++;
        if (first_valid !== 3) begin
            errors++;
            $display("FAIL full_first_valid: got %0d required 3", first_valid);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 194) begin
            errors++;
            $display("FAIL full_done: count=%0d at=%0d required 1 at 194", done_cnt, done_at);
        end
        checks++;
        if (stall_cnt !== 193 || first_stall !== 1 || last_stall !== 193) begin
            errors++;
            $display("FAIL full_stall: cnt=%0d first=%0d last=%0d required 193 1 193",
                     stall_cnt, first_stall, last_stall);
        end
        n = addr_err();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL full_read_addrs: %0d bad of %0d reads required 0 of 32",
                     n, raddrs.size());
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL full_read_stall: got %0d reads without stall required 0", stall_viol);
        end
    endtask

    task automatic test_backpressure();
        int n;
        run_dump(1, 1'b0);
        n = stream_err();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL bp_stream: %0d bad of %0d bytes required 0 bad of 128",
                     n, rx_bytes.size());
        end
        checks++;
        if (stable_viol !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles required 0", stable_viol);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL bp_done: got %0d required 1", done_cnt);
        end
        n = addr_err();
        checks++;
        if (n !== 0 || stall_viol !== 0) begin
            errors++;
            $display("FAIL bp_reads: bad=%0d stall_viol=%0d required 0 0", n, stall_viol);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        run_dump(0, 1'b1);
        n = stream_err();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL busy_stream: %0d bad of %0d bytes required 0", n, rx_bytes.size());
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 194) begin
            errors++;
            $display("FAIL busy_done: count=%0d at=%0d required 1 at 194", done_cnt, done_at);
        end
        checks++;
        if (stall_cnt !== 193 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_restart: stall_cnt=%0d busy=%b required 193 0", stall_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            rel = c;
            start = 1'b0;
            @(negedge clk);
            sample();
            if (tx_valid && rx_bytes.size() == 23) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || tx_data !== 8'h00 || rd_addr !== 5'd5) begin
            errors++;
            $display("FAIL mid_position: hit=%b data=%h addr=%0d required 1 00 5",
                     hit, tx_data, rd_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, busy, rd_en, tx_valid, done, rd_addr, tx_data} !== 18'h0) begin
            errors++;
            $display("FAIL mid_async_clear: stall=%b busy=%b valid=%b addr=%0d required all 0",
                     stall, busy, tx_valid, rd_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_stats();
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            rel = c;
            @(negedge clk);
            sample();
        end
        checks++;
        if (done_cnt !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL mid_no_done: done=%0d stall=%0d required 0 0", done_cnt, stall_cnt);
        end
        run_dump(0, 1'b0);
        checks++;
        if (rx_bytes.size() == 0 || rx_bytes[0] !== 8'h00 || raddrs.size() == 0 || raddrs[0] != 0) begin
            errors++;
            $display("FAIL mid_restart_first: bytes=%0d reads=%0d required first byte 00 at reg 0",
                     rx_bytes.size(), raddrs.size());
        end
        checks++;
        if (stream_err() !== 0 || done_at !== 194) begin
            errors++;
            $display("FAIL mid_restart_full: bad=%0d done_at=%0d required 0 194",
                     stream_err(), done_at);
        end
    endtask

    task automatic test_small();
        logic [7:0] got[$];
        logic [7:0] exp [4];
        int d_cnt = 0;
        int d_at = -1;
        int bad = 0;
        exp[0] = 8'hA0; exp[1] = 8'hC3; exp[2] = 8'hA1; exp[3] = 8'hC3;
        @(posedge clk); #1;
        start2 = 1'b1;
        ready2 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            @(negedge clk);
            if (tx_valid2 && ready2) got.push_back(tx_data2);
            if (done2) begin
                d_cnt++;
                d_at = c;
            end
        end
        if (got.size() != 4) bad++;
        for (int i = 0; i < got.size() && i < 4; i++)
            if (got[i] !== exp[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL small_stream: %0d bad of %0d bytes required 0 of 4", bad, got.size());
        end
        checks++;
        if (d_cnt !== 1 || d_at !== 10) begin
            errors++;
            $display("FAIL small_done: count=%0d at=%0d required 1 at 10", d_cnt, d_at);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regbank_dump_ctrl.md
Name: regbank_dump_ctrl

Overview:
- Debug-unit sequencer that dumps the ID-stage register bank over a byte-wide transmit handshake.
- On a start pulse it stalls the pipeline, then reads registers 0..NUM_REGS-1 one at a time through the bank's debug read port.
- Each 32-bit word goes out as 4 bytes, LSB first, to the UART TX front-end.
- Sits between the debug unit's command decoder, the register bank, and the TX byte interface.

Parameters:
- DATA_SIZE, 32, register width in bits; must be a multiple of BYTE_SIZE.
- ADDR_SIZE, 5, register address width.
- NUM_REGS, 32, number of registers dumped; must be ≤ 2^ADDR_SIZE.
- BYTE_SIZE, 8, TX byte width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  dump request pulse from the debug command decoder.
- o_stall  out  1  high while the dump is active; drives pipeline/bank i_enable low.
- o_read_enable  out  1  bank debug read strobe.
- o_read_addr  out  ADDR_SIZE  bank debug read address.
- i_reg_data  in  DATA_SIZE  bank o_data_a; registered, valid one cycle after the read strobe.
- o_tx_data  out  BYTE_SIZE  byte to transmit.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  TX accepts the byte on a cycle where valid and ready are both high.
- o_busy  out  1  high when the state is not IDLE.
- o_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, i_reset=0): state=IDLE; addr=0; byte_cnt=0; shift register=0. All outputs 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- o_stall = o_busy = (state != IDLE).
- States:
  - IDLE: i_start=1 -> READ with addr=0. Otherwise stay.
  - READ (1 cycle): o_read_enable=1, o_read_addr=addr. Always -> CAPTURE.
  - CAPTURE (1 cycle): shift register <= i_reg_data; byte_cnt <= 0. -> SEND.
  - SEND: o_tx_valid=1, o_tx_data=shift[BYTE_SIZE-1:0].
    - On handshake: shift >>= BYTE_SIZE; byte_cnt++.
    - If byte_cnt was DATA_SIZE/BYTE_SIZE-1: addr==NUM_REGS-1 -> DONE, else addr++ -> READ.
    - No handshake: hold o_tx_data and o_tx_valid stable.
  - DONE (1 cycle): o_done=1; addr<=0. -> IDLE.
- o_stall is already high in READ because it is registered from the IDLE->READ transition. The bank therefore never sees i_enable and read_enable together.
- i_start while busy: ignored, with no restart and no queueing.
- i_start held high across DONE->IDLE: a new dump starts on the first IDLE cycle it is sampled.
- Latency:
  - i_start to first o_tx_valid = 3 cycles (IDLE sample, READ, CAPTURE).
  - Per-register overhead outside SEND = 2 cycles.
  - Minimum dump time with i_tx_ready tied high = 1 + NUM_REGS*(2+DATA_SIZE/BYTE_SIZE) + 1 cycles; 194 with defaults.
- i_tx_ready high outside SEND: no effect.
- Reset mid-dump: immediate return to IDLE. o_stall drops asynchronously. No o_done is produced. A partially sent word is abandoned.
- addr never wraps; the DONE path resets it to 0.

Decomposition:
- Shared debug package holds:
  - state encoding localparams (IDLE, READ, CAPTURE, SEND, DONE; 3 bits);
  - BYTES_PER_WORD = DATA_SIZE/BYTE_SIZE;
  - the NUM_REGS default.
- One natural sub-module: word_serializer. It does the load / shift-out of a DATA_SIZE word into BYTE_SIZE chunks with a valid/ready handshake and a last-byte flag. The FSM stays in regbank_dump_ctrl.

Test Plan:
1. Bank model with reg[k]=32'h1000_0000+k, i_tx_ready=1, pulse i_start -> 128 bytes, starting 00 00 00 10 01 00 00 10 … 1F 00 00 10. o_done one cycle at cycle 194; o_stall high for exactly cycles 1..193.
2. Same bank, i_tx_ready toggling 1-0-0 repeatedly -> identical byte stream. o_tx_data stable whenever valid && !ready. No byte duplicated or lost.
3. Protocol check across the whole run -> o_read_enable pulses exactly 32 times with addresses 0..31 in order. o_stall is 1 on every cycle where o_read_enable=1.
4. i_start pulsed again at register 10 of a dump -> ignored. Exactly 128 bytes and one o_done.
5. i_reset asserted low during SEND of register 5, byte 2 -> all outputs 0 immediately. No o_done. A fresh i_start afterwards restarts at register 0 and byte 0 (first byte 00).
6. NUM_REGS=2, DATA_SIZE=16 -> 4 bytes, reg0 LSB/MSB then reg1 LSB/MSB. o_done after the fourth handshake.
